// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared constants, state type and GF(2^8) helpers for AES-128 key expansion
package aes_pkg;

    localparam int NUM_ROUNDS = 10;
    localparam int KEY_W      = 128;

    // Round constants for rounds 1..10; the sequencer starts from RCON[0] and walks it with xtime
    localparam logic [7:0] RCON [NUM_ROUNDS] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    typedef enum logic [1:0] {
        IDLE,
        EXPAND,
        READY
    } state_e;

    // Forward S-box, entry 0 in the most significant byte
    localparam logic [2047:0] SBOX_TBL = {
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Entry x sits (255-x) bytes up from bit 0, and 255-x is simply ~x for a byte
    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX_TBL[{~x, 3'b000} +: 8];
    endfunction

    // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_key_sched_ctrl_if.sv
// rtl/aes_key_sched_ctrl_if.sv - host key-load and round-key read port bundle
interface aes_key_sched_ctrl_if;

    logic                        key_load;
    logic [aes_pkg::KEY_W-1:0]   key_in;
    logic                        busy;
    logic                        keys_ready;
    logic                        load_err;
    logic                        rd_req;
    logic [3:0]                  rd_round;
    logic                        rd_ready;
    logic                        rd_valid;
    logic [aes_pkg::KEY_W-1:0]   rd_key;
    logic                        rd_err;

    modport master (
        output key_load, key_in, rd_req, rd_round,
        input  busy, keys_ready, load_err, rd_ready, rd_valid, rd_key, rd_err
    );

    modport slave (
        input  key_load, key_in, rd_req, rd_round,
        output busy, keys_ready, load_err, rd_ready, rd_valid, rd_key, rd_err
    );

endinterface

// File: rtl/aes_key_round.sv
// rtl/aes_key_round.sv - one combinational AES-128 key-expansion step
module aes_key_round
    import aes_pkg::*;
(
    input  logic [KEY_W-1:0] w_i,
    input  logic [7:0]       rc_i,
    output logic [KEY_W-1:0] w_o
);

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] t;
    logic [31:0] n0, n1, n2, n3;

    assign w0 = w_i[127:96];
    assign w1 = w_i[95:64];
    assign w2 = w_i[63:32];
    assign w3 = w_i[31:0];

    // SubWord(RotWord(w3)) with the round constant folded into the top byte
    assign t = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rc_i, 24'h0};

    // Each new word chains off the previous new word
    assign n0 = w0 ^ t;
    assign n1 = w1 ^ n0;
    assign n2 = w2 ^ n1;
    assign n3 = w3 ^ n2;

    assign w_o = {n0, n1, n2, n3};

endmodule

// File: rtl/aes_key_sched_ctrl.sv
// rtl/aes_key_sched_ctrl.sv - AES-128 key expansion sequencer with round-key file and read port
module aes_key_sched_ctrl
    import aes_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    aes_key_sched_ctrl_if.slave  bus
);

    localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

    state_e             state_q, state_d;
    logic [3:0]         cnt_q;
    logic [3:0]         wr_cnt_q;
    logic [7:0]         rcon_q;
    logic [KEY_W-1:0]   work_q;
    logic [KEY_W-1:0]   step_key;
    logic [KEY_W-1:0]   key_file [NUM_ROUNDS+1];

    logic               load_acc;
    logic               expanding;
    logic               rd_oob;
    logic               rd_hit;

    logic               load_err_q;
    logic               rd_valid_q;
    logic               rd_err_q;
    logic [KEY_W-1:0]   rd_key_q;

    aes_key_round u_round (
        .w_i  (work_q),
        .rc_i (rcon_q),
        .w_o  (step_key)
    );

    // Next state plus the load-accept / expand-step strobes
    always_comb begin
        state_d   = state_q;
        load_acc  = 1'b0;
        expanding = 1'b0;
        case (state_q)
            IDLE, READY: begin
                if (bus.key_load) begin
                    load_acc = 1'b1;
                    state_d  = EXPAND;
                end
            end
            EXPAND: begin
                expanding = 1'b1;
                if (cnt_q == LAST_ROUND) begin
                    state_d = READY;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Round counter, round constant, written-count and dropped-load flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q      <= 4'd0;
            rcon_q     <= RCON[0];
            wr_cnt_q   <= 4'd0;
            load_err_q <= 1'b0;
        end else begin
            load_err_q <= expanding & bus.key_load;
            if (load_acc) begin
                cnt_q    <= 4'd1;
                rcon_q   <= RCON[0];
                wr_cnt_q <= 4'd1;
            end else if (expanding) begin
                cnt_q    <= cnt_q + 4'd1;
                rcon_q   <= xtime(rcon_q);
                wr_cnt_q <= wr_cnt_q + 4'd1;
            end
        end
    end

    // Key file and work register; contents are gated by wr_cnt_q, so no reset is needed
    always_ff @(posedge clk) begin
        if (load_acc) begin
            key_file[0] <= bus.key_in;
            work_q      <= bus.key_in;
        end else if (expanding) begin
            key_file[cnt_q] <= step_key;
            work_q          <= step_key;
        end
    end

    // A read is taken when the round is already written or out of range, unless a load claims the cycle
    assign rd_oob       = bus.rd_round > LAST_ROUND;
    assign rd_hit       = bus.rd_round < wr_cnt_q;
    assign bus.rd_ready = bus.rd_req & ~load_acc & (rd_oob | rd_hit);

    // Registered read response; rd_key holds between reads
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_valid_q <= 1'b0;
            rd_err_q   <= 1'b0;
            rd_key_q   <= '0;
        end else begin
            rd_valid_q <= bus.rd_ready;
            if (bus.rd_ready) begin
                rd_err_q <= rd_oob;
                rd_key_q <= rd_oob ? '0 : key_file[bus.rd_round];
            end else begin
                rd_err_q <= 1'b0;
            end
        end
    end

    assign bus.busy       = (state_q == EXPAND);
    assign bus.keys_ready = (state_q == READY);
    assign bus.load_err   = load_err_q;
    assign bus.rd_valid   = rd_valid_q;
    assign bus.rd_err     = rd_err_q;
    assign bus.rd_key     = rd_key_q;

endmodule
